// File: rtl/jtag_seq.sv
// rtl/jtag_seq.sv - command-driven JTAG TAP shift sequencer (optional TRST output under JTAG_SEQ_TRST_EN)
module jtag_seq #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [$clog2(DATA_W)-1:0]  cmd_len,
    input  logic [DATA_W-1:0]          cmd_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       tck,
    output logic                       tms,
    output logic                       tdi,
    input  logic                       tdo,
    output logic                       busy
`ifdef JTAG_SEQ_TRST_EN
    ,
    output logic                       trst_n
`endif
);

    localparam int LW = $clog2(DATA_W);
    // Bit index must also cover the 6-step reset walk, even for tiny DATA_W.
    localparam int IW = (LW > 3) ? LW : 3;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    // S_TRST only exists in builds with the TRST pin; it is one TCK period with tck held low.
    typedef enum logic [2:0] {
        S_IDLE,
        S_TRST,
        S_SYNC,
        S_PRE,
        S_SHIFT,
        S_POST,
        S_RESP
    } state_t;

    state_t             state;
    state_t             nxt_state;
    state_t             acc_state;
    logic [1:0]         op_r;
    logic [LW-1:0]      len_r;
    logic [DATA_W-1:0]  data_r;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      nxt_idx;
    logic [IW-1:0]      phase_end;
    logic [DW-1:0]      div_cnt;
    logic               hi;
    logic               tap_sync;

    // TMS value for bit i of a given phase; the shift phase raises TMS on its last bit to leave Shift-xR.
    function automatic logic tms_at(state_t s, logic [IW-1:0] i, logic [1:0] op, logic [LW-1:0] len);
        logic t;
        case (s)
            S_TRST:  t = 1'b1;
            S_SYNC:  t = (i < IW'(5));
            S_PRE:   t = (op == OP_IR) ? (i < IW'(2)) : (i == '0);
            S_SHIFT: t = (op != OP_IDLE) && (i == IW'(len));
            S_POST:  t = (i == '0);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // TDI carries payload only while shifting a real IR/DR; idle clocks and walks drive 0.
    function automatic logic tdi_at(state_t s, logic [IW-1:0] i, logic [1:0] op, logic [DATA_W-1:0] data);
        logic t;
        t = 1'b0;
        if (s == S_SHIFT && op != OP_IDLE) begin
            t = data[i[LW-1:0]];
        end
        return t;
    endfunction

    // First phase after accept: unsynchronised TAPs (and explicit resets) walk through Test-Logic-Reset first.
    always_comb begin
        acc_state = S_PRE;
        if (cmd_op == OP_RESET || !tap_sync) begin
`ifdef JTAG_SEQ_TRST_EN
            acc_state = S_TRST;
`else
            acc_state = S_SYNC;
`endif
        end else if (cmd_op == OP_IDLE) begin
            acc_state = S_SHIFT;
        end
    end

    // Next (phase, bit) once the current TCK period completes.
    always_comb begin
        phase_end = '0;
        nxt_state = state;
        nxt_idx   = idx + 1'b1;
        case (state)
            S_SYNC:  phase_end = IW'(5);
            S_PRE:   phase_end = (op_r == OP_IR) ? IW'(3) : IW'(2);
            S_SHIFT: phase_end = IW'(len_r);
            S_POST:  phase_end = IW'(1);
            default: phase_end = '0;
        endcase
        if (idx == phase_end) begin
            nxt_idx = '0;
            case (state)
                S_TRST:  nxt_state = S_SYNC;
                S_SYNC:  nxt_state = (op_r == OP_RESET) ? S_RESP :
                                     (op_r == OP_IDLE)  ? S_SHIFT : S_PRE;
                S_PRE:   nxt_state = S_SHIFT;
                S_SHIFT: nxt_state = (op_r == OP_IDLE) ? S_RESP : S_POST;
                default: nxt_state = S_RESP;
            endcase
        end
    end

    // Sequencer: command accept, TCK generation, TMS/TDI update on falling edges, TDO capture on rising edges, response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_r      <= OP_RESET;
            len_r     <= '0;
            data_r    <= '0;
            idx       <= '0;
            div_cnt   <= '0;
            hi        <= 1'b0;
            tap_sync  <= 1'b0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
`ifdef JTAG_SEQ_TRST_EN
            trst_n    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
`ifdef JTAG_SEQ_TRST_EN
                    trst_n <= 1'b1;
`endif
                    if (cmd_valid && cmd_ready) begin
                        op_r      <= cmd_op;
                        len_r     <= cmd_len;
                        data_r    <= cmd_data;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        rsp_data  <= '0;
                        state     <= acc_state;
                        idx       <= '0;
                        div_cnt   <= '0;
                        hi        <= 1'b0;
                        tck       <= 1'b0;
                        tms       <= tms_at(acc_state, '0, cmd_op, cmd_len);
                        tdi       <= tdi_at(acc_state, '0, cmd_op, cmd_data);
`ifdef JTAG_SEQ_TRST_EN
                        trst_n    <= (acc_state != S_TRST);
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    if (div_cnt != DW'(CLK_DIV - 1)) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!hi) begin
                            hi  <= 1'b1;
                            tck <= (state != S_TRST);
                            if (state == S_SHIFT && op_r != OP_IDLE) begin
                                rsp_data[idx[LW-1:0]] <= tdo;
                            end
                        end else begin
                            hi    <= 1'b0;
                            tck   <= 1'b0;
                            state <= nxt_state;
                            idx   <= nxt_idx;
`ifdef JTAG_SEQ_TRST_EN
                            trst_n <= 1'b1;
`endif
                            if (state == S_SYNC && nxt_state != S_SYNC) begin
                                tap_sync <= 1'b1;
                            end
                            if (nxt_state == S_RESP) begin
                                // TMS keeps its final 0 so the TAP parks in Run-Test/Idle.
                                rsp_valid <= 1'b1;
                                tdi       <= 1'b0;
                            end else begin
                                tms <= tms_at(nxt_state, nxt_idx, op_r, len_r);
                                tdi <= tdi_at(nxt_state, nxt_idx, op_r, data_r);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_seq.sv
// tb/tb_jtag_seq.sv - self-checking bench for jtag_seq with a behavioural TAP model
module tb_jtag_seq;
    localparam int DATA_W  = 32;
    localparam int CLK_DIV = 2;
    localparam int LW      = $clog2(DATA_W);
`ifdef JTAG_SEQ_TRST_EN
    localparam int TRST_CYC = 2 * CLK_DIV;
`else
    localparam int TRST_CYC = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [LW-1:0]     cmd_len = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              tck, tms, tdi;
    logic              tdo = 1'b0;
    logic              busy;
    logic              trst_w;
`ifdef JTAG_SEQ_TRST_EN
    logic              trst_n;
    assign trst_w = trst_n;
`else
    assign trst_w = 1'b1;
`endif

    jtag_seq #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
`ifdef JTAG_SEQ_TRST_EN
        , .trst_n(trst_n)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit synced = 1'b0;

    // Behavioural IEEE 1149.1 TAP
    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7, UPDR = 8;
    localparam int SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;
    int          tap_st = SHDR;
    logic [63:0] m_sr = '0;
    logic [63:0] dr_out = '0;
    logic [63:0] ir_out = '0;
    logic [63:0] dr_load = '0;
    logic [63:0] ir_cap = '0;
    int          dr_len = 1;
    int          ir_len = 1;
    int          tck_cnt = 0;
    logic [63:0] tms_hist = '0;

    function automatic logic [63:0] lenmask(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDR  : PADR;
            PADR:    return m ? EX2DR : PADR;
            EX2DR:   return m ? UPDR  : SHDR;
            UPDR:    return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPIR  : PAIR;
            PAIR:    return m ? EX2IR : PAIR;
            EX2IR:   return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck or negedge trst_w) begin
        if (!trst_w) begin
            tap_st <= TLR;
        end else begin
            tck_cnt  <= tck_cnt + 1;
            tms_hist <= {tms_hist[62:0], tms};
            case (tap_st)
                CAPDR:   m_sr <= dr_load & lenmask(dr_len);
                SHDR:    m_sr <= (m_sr >> 1) | (64'(tdi) << (dr_len - 1));
                UPDR:    dr_out <= m_sr;
                CAPIR:   m_sr <= ir_cap & lenmask(ir_len);
                SHIR:    m_sr <= (m_sr >> 1) | (64'(tdi) << (ir_len - 1));
                UPIR:    ir_out <= m_sr;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    always @(negedge tck) begin
        tdo <= (tap_st == SHDR || tap_st == SHIR) ? m_sr[0] : 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, check TCK count, TMS pattern, latency, handshake rules; return captured data.
    task automatic run_cmd(input string tag, input int op, input int len, input logic [DATA_W-1:0] data,
                           input int hold, output logic [63:0] rsp);
        logic [63:0]       ep;
        logic [DATA_W-1:0] snap;
        int                en, lat, trl, c0;
        bit                sy, stable;
        ep = '0;
        en = 0;
        sy = !synced || (op == 0);
        if (sy) begin
            for (int i = 0; i < 6; i++) begin ep = {ep[62:0], (i < 5)}; en++; end
        end
        if (op == 1) begin ep = {ep[59:0], 4'b1100}; en += 4; end
        if (op == 2) begin ep = {ep[60:0], 3'b100};  en += 3; end
        if (op == 3) begin
            for (int i = 0; i <= len; i++) begin ep = {ep[62:0], 1'b0}; en++; end
        end
        if (op == 1 || op == 2) begin
            for (int i = 0; i <= len; i++) begin ep = {ep[62:0], (i == len)}; en++; end
            ep = {ep[61:0], 2'b10};
            en += 2;
        end

        @(negedge clk);
        check({tag, ".ready_idle"}, cmd_ready, 1);
        c0        = tck_cnt;
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        cmd_len   = len[LW-1:0];
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = LW'($urandom);
        cmd_data  = DATA_W'($urandom);
        @(negedge clk);
        check({tag, ".ready_low"}, cmd_ready, 0);
        check({tag, ".busy_high"}, busy, 1);
        lat = 1;
        trl = 0;
        while (lat < 4000) begin
            if (rsp_valid) break;
            if (!trst_w) trl++;
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, 1 + 2 * CLK_DIV * en + (sy ? TRST_CYC : 0));
        check({tag, ".tck_low_at_rsp"}, tck, 0);
        check({tag, ".tck_count"}, tck_cnt - c0, en);
        check({tag, ".tms_pattern"}, tms_hist & lenmask(en), ep);
        check({tag, ".trst_low_cycles"}, trl, sy ? TRST_CYC : 0);
        snap   = rsp_data;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== snap || cmd_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        end
        if (hold > 0) check({tag, ".hold_stable"}, stable, 1);
        rsp = 64'(rsp_data);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, ".valid_drop"}, rsp_valid, 0);
        check({tag, ".ready_back"}, cmd_ready, 1);
        check({tag, ".busy_drop"}, busy, 0);
        synced = 1'b1;
    endtask

    logic [63:0] r;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst.tck", tck, 0);
        check("rst.tms", tms, 1);
        check("rst.tdi", tdi, 0);
        check("rst.cmd_ready", cmd_ready, 1);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.rsp_data", rsp_data, 0);
        check("rst.busy", busy, 0);
`ifdef JTAG_SEQ_TRST_EN
        check("rst.trst_n", trst_n, 0);
`endif
        rst = 1'b0;
        synced = 1'b0;
        repeat (3) @(negedge clk);
`ifdef JTAG_SEQ_TRST_EN
        check("idle.trst_n", trst_n, 1);
`endif

        // TAP_RESET
        run_cmd("tap_reset", 0, 0, '1, 0, r);
        check("tap_reset.rsp", r, 0);
        check("tap_reset.tap_state", tap_st, RTI);

        // Reset pulse while idle
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_idle.tms", tms, 1);
        check("rst_idle.cmd_ready", cmd_ready, 1);
        check("rst_idle.busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        synced = 1'b0;

        // First DR shift after reset auto-synchronises
        dr_load = 64'h12345678;
        dr_len  = 32;
        run_cmd("dr_sync", 2, 31, 32'hDEADBEEF, 0, r);
        check("dr_sync.rsp", r, 64'h12345678);
        check("dr_sync.model_dr", dr_out, 64'hDEADBEEF);
        check("dr_sync.tap_state", tap_st, RTI);

        // IR shift with response backpressure
        ir_cap = 64'h01;
        ir_len = 5;
        run_cmd("ir_bp", 1, 4, 32'h11, 10, r);
        check("ir_bp.rsp", r, 64'h01);
        check("ir_bp.model_ir", ir_out, 64'h11);

        // Randomised commands against the TAP model
        for (int k = 0; k < 10; k++) begin
            int          op, len;
            logic [63:0] d, dl, ic, er, mk;
            op = int'($urandom_range(0, 3));
            len = int'($urandom_range(0, DATA_W - 1));
            d  = 64'($urandom);
            dl = 64'($urandom);
            ic = 64'($urandom);
            mk = lenmask(len + 1);
            dr_load = dl;
            dr_len  = len + 1;
            ir_cap  = ic;
            ir_len  = len + 1;
            er = (op == 2) ? (dl & mk) : (op == 1) ? (ic & mk) : 64'd0;
            run_cmd($sformatf("rnd%0d_op%0d", k, op), op, len, d[DATA_W-1:0], int'($urandom_range(0, 5)), r);
            check($sformatf("rnd%0d.rsp", k), r, er);
            check($sformatf("rnd%0d.tap_state", k), tap_st, RTI);
            if (op == 2) check($sformatf("rnd%0d.model_dr", k), dr_out, d & mk);
            if (op == 1) check($sformatf("rnd%0d.model_ir", k), ir_out, d & mk);
        end

        // Reset in the middle of a DR shift
        dr_len = 32;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = LW'(DATA_W - 1);
        cmd_data  = DATA_W'($urandom);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (51) @(negedge clk);
        check("mid.tck_high_before", tck, 1);
        #2 rst = 1'b1;
        #1;
        check("mid.tck", tck, 0);
        check("mid.tms", tms, 1);
        check("mid.tdi", tdi, 0);
        check("mid.busy", busy, 0);
        check("mid.cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        synced = 1'b0;
        run_cmd("idle_after_rst", 3, 3, '1, 0, r);
        check("idle_after_rst.rsp", r, 0);
        check("idle_after_rst.tap_state", tap_st, RTI);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
